// File: rtl/pll_lock_detect.sv
// pll_lock_detect: refclk-domain PLL frequency monitor with hysteretic lock flag.
// Optional build macro CANARY_LOCK_FREQ_ERR_EN adds the signed freq_err register.
module pll_lock_detect #(
    parameter int CW         = 16,
    parameter int WINDOW     = 64,
    parameter int TOL        = 4,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic          refclk,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    divn,
    input  logic [CW-1:0] pclk_cnt_gray,
    output logic [CW-1:0] freq_count,
    output logic          count_valid,
    output logic          locked,
    output logic          lost_lock,
    output logic [CW-1:0] freq_err
);
    localparam int WW = $clog2(WINDOW);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, PRIME, MEASURE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] sync1_q, sync1_d, sync2_q, sync2_d, cur_bin_q, cur_bin_d;
    logic [CW-1:0] prev_q, prev_d, freq_count_q, freq_count_d;
    logic [WW-1:0] win_q, win_d;
    logic [7:0]    divn_q, divn_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          count_valid_q, count_valid_d, locked_q, locked_d, lost_lock_q, lost_lock_d;
    logic [CW-1:0] delta, diff, abs_err;
    logic          we, good, retarget;
`ifdef CANARY_LOCK_FREQ_ERR_EN
    logic [CW-1:0] freq_err_q, freq_err_d;
`endif

    // Window arithmetic: modular delta absorbs Gray counter wrap through zero.
    always_comb begin
        we       = win_q == WW'(WINDOW - 1);
        delta    = cur_bin_q - prev_q;
        diff     = delta - CW'(divn_q) * CW'(WINDOW);
        abs_err  = diff[CW-1] ? -diff : diff;
        good     = abs_err <= CW'(TOL);
        retarget = (state_q == MEASURE || state_q == LOCKED) && divn != divn_q;
    end

    // Synchronizer, Gray decode, window counter and lock FSM next state.
    always_comb begin
        sync1_d       = pclk_cnt_gray;
        sync2_d       = sync1_q;
        cur_bin_d     = '0;
        for (int i = 0; i < CW; i++) cur_bin_d[i] = ^(sync2_q >> i);
        state_d       = state_q;
        win_d         = '0;
        prev_d        = prev_q;
        divn_d        = divn_q;
        good_d        = good_q;
        bad_d         = bad_q;
        freq_count_d  = freq_count_q;
        count_valid_d = 1'b0;
        locked_d      = locked_q;
        lost_lock_d   = 1'b0;
`ifdef CANARY_LOCK_FREQ_ERR_EN
        freq_err_d    = freq_err_q;
`endif
        if (!enable) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            good_d   = '0;
            bad_d    = '0;
        end else if (state_q == IDLE || retarget) begin
            state_d  = PRIME;
            divn_d   = divn;
            locked_d = 1'b0;
            good_d   = '0;
            bad_d    = '0;
        end else begin
            win_d = we ? '0 : win_q + 1'b1;
            if (state_q == PRIME) begin
                divn_d = divn;
                if (we) begin
                    prev_d  = cur_bin_q;
                    state_d = MEASURE;
                end
            end else if (we) begin
                prev_d        = cur_bin_q;
                freq_count_d  = delta;
                count_valid_d = 1'b1;
`ifdef CANARY_LOCK_FREQ_ERR_EN
                freq_err_d    = diff;
`endif
                if (state_q == MEASURE) begin
                    good_d = good ? good_q + 1'b1 : '0;
                    bad_d  = '0;
                    if (good && good_q == GW'(LOCK_CNT - 1)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        good_d   = '0;
                    end
                end else begin
                    bad_d = good ? '0 : bad_q + 1'b1;
                    if (!good && bad_q == BW'(UNLOCK_CNT - 1)) begin
                        state_d     = MEASURE;
                        locked_d    = 1'b0;
                        lost_lock_d = 1'b1;
                        good_d      = '0;
                        bad_d       = '0;
                    end
                end
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            cur_bin_q     <= '0;
            prev_q        <= '0;
            win_q         <= '0;
            divn_q        <= '0;
            good_q        <= '0;
            bad_q         <= '0;
            freq_count_q  <= '0;
            count_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            lost_lock_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cur_bin_q     <= cur_bin_d;
            prev_q        <= prev_d;
            win_q         <= win_d;
            divn_q        <= divn_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            freq_count_q  <= freq_count_d;
            count_valid_q <= count_valid_d;
            locked_q      <= locked_d;
            lost_lock_q   <= lost_lock_d;
        end
    end

`ifdef CANARY_LOCK_FREQ_ERR_EN
    // Signed frequency error, refreshed with each count_valid.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) freq_err_q <= '0;
        else       freq_err_q <= freq_err_d;
    end

    assign freq_err = freq_err_q;
`else
    assign freq_err = '0;
`endif

    assign freq_count  = freq_count_q;
    assign count_valid = count_valid_q;
    assign locked      = locked_q;
    assign lost_lock   = lost_lock_q;
endmodule

// File: tb/tb_pll_lock_detect.sv
// tb_pll_lock_detect: directed stimulus against a window-arithmetic model of the lock monitor.
module tb_pll_lock_detect;
    localparam int WIN = 64, TOL = 4, LOCK = 4, UNLOCK = 2;

    logic        refclk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [7:0]  divn = 8'd27;
    logic [15:0] pclk_cnt_gray = '0;
    logic [15:0] freq_count, freq_err;
    logic        count_valid, locked, lost_lock;

    pll_lock_detect dut (
        .refclk(refclk), .reset(reset), .enable(enable), .divn(divn),
        .pclk_cnt_gray(pclk_cnt_gray), .freq_count(freq_count), .count_valid(count_valid),
        .locked(locked), .lost_lock(lost_lock), .freq_err(freq_err)
    );

    always #5 refclk = ~refclk;

    int compared = 0, mismatched = 0;
    int cyc = 0, rate = 27, inj = 0, t0 = 0;
    logic [15:0] cnt = '0;
    logic [15:0] hist [0:16383];

    bit          run = 0;
    int          start = 0, goods = 0, bads = 0;
    logic [7:0]  mdivn = '0;
    logic [15:0] prev = '0;
    logic [15:0] e_fc = '0, e_fe = '0;
    logic        e_cv = 0, e_lk = 0, e_ll = 0;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected outputs for cycle cyc+1, from the window rules applied to the driven count history.
    task automatic model();
        int ph, err;
        bit ok;
        logic [15:0] d, d16;
        if (reset) begin
            run = 0; e_fc = 0; e_fe = 0; e_cv = 0; e_lk = 0; e_ll = 0;
            return;
        end
        e_cv = 0; e_ll = 0;
        if (!enable) begin
            run = 0; e_lk = 0;
        end else if (!run) begin
            run = 1; start = cyc + 1; mdivn = divn; goods = 0; bads = 0; e_lk = 0;
        end else begin
            ph = cyc - start;
            if (ph >= WIN && divn != mdivn) begin
                start = cyc + 1; mdivn = divn; goods = 0; bads = 0; e_lk = 0;
            end else if (ph < WIN) begin
                mdivn = divn;
                if (ph == WIN - 1) prev = hist[cyc-3];
            end else if (ph % WIN == WIN - 1) begin
                d = hist[cyc-3] - prev;
                prev = hist[cyc-3];
                d16 = d - 16'(int'(mdivn) * WIN);
                err = int'($signed(d16));
                ok = err <= TOL && err >= -TOL;
                e_cv = 1; e_fc = d;
`ifdef CANARY_LOCK_FREQ_ERR_EN
                e_fe = d16;
`endif
                if (!e_lk) begin
                    goods = ok ? goods + 1 : 0;
                    if (goods == LOCK) begin e_lk = 1; bads = 0; end
                end else begin
                    bads = ok ? 0 : bads + 1;
                    if (bads == UNLOCK) begin e_lk = 0; e_ll = 1; goods = 0; bads = 0; end
                end
            end
        end
    endtask

    // One refclk cycle: drive the pclk count, advance the model, then compare every output.
    task automatic step();
        cnt = cnt + 16'(rate + inj);
        inj = 0;
        pclk_cnt_gray = cnt ^ (cnt >> 1);
        hist[cyc] = cnt;
        model();
        @(posedge refclk);
        cyc++;
        #1;
        compared++;
        if (freq_count !== e_fc || count_valid !== e_cv || locked !== e_lk || lost_lock !== e_ll || freq_err !== e_fe) begin
            mismatched++;
            $display("FAIL model cyc %0d: got fc=%0d cv=%b lk=%b ll=%b fe=%0d expected fc=%0d cv=%b lk=%b ll=%b fe=%0d",
                     cyc, freq_count, count_valid, locked, lost_lock, freq_err, e_fc, e_cv, e_lk, e_ll, e_fe);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_cv(input string nm);
        int n = 0;
        do begin step(); n++; end while (count_valid !== 1'b1 && n < 200);
        if (count_valid !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL %s: got no count_valid in 200 cycles expected a pulse", nm);
        end
    endtask

    initial begin
        int seen;
        steps(3);
        reset = 0;
        steps(4);
        chk("reset_fc", int'(freq_count), 0);
        chk("reset_lk", int'(locked), 0);
        chk("reset_cv", int'(count_valid), 0);

        // Nominal lock at divn=27.
        enable = 1;
        t0 = cyc + 1;
        while (cyc < t0 + 127) step();
        chk("nom_no_cv_127", int'(count_valid), 0);
        step();
        chk("nom_cv_128", int'(count_valid), 1);
        chk("nom_fc_128", int'(freq_count), 1728);
        while (cyc < t0 + 319) step();
        chk("nom_unlocked_319", int'(locked), 0);
        step();
        chk("nom_locked_320", int'(locked), 1);
        chk("nom_cv_320", int'(count_valid), 1);

        // Tolerance band.
        wait_cv("tol_sync");
        inj = 4;
        wait_cv("tol_1732");
        chk("tol_fc_1732", int'(freq_count), 1732);
        chk("tol_lk_1732", int'(locked), 1);
        inj = 5;
        wait_cv("tol_1733");
        chk("tol_fc_1733", int'(freq_count), 1733);
        chk("tol_lk_1733", int'(locked), 1);
`ifdef CANARY_LOCK_FREQ_ERR_EN
        chk("tol_fe_1733", int'($signed(freq_err)), 5);
`endif
        inj = -4;
        wait_cv("tol_1724");
        chk("tol_fc_1724", int'(freq_count), 1724);
        chk("tol_lk_1724", int'(locked), 1);

        // Loss of lock after two bad windows, then relock.
        inj = -128;
        wait_cv("loss_1");
        chk("loss_fc_1", int'(freq_count), 1600);
        chk("loss_lk_1", int'(locked), 1);
        chk("loss_ll_1", int'(lost_lock), 0);
        inj = -128;
        wait_cv("loss_2");
        chk("loss_ll_2", int'(lost_lock), 1);
        chk("loss_lk_2", int'(locked), 0);
        step();
        chk("loss_ll_once", int'(lost_lock), 0);
        for (int i = 0; i < 4; i++) begin
            wait_cv("relock");
            chk("relock_lk", int'(locked), i == 3 ? 1 : 0);
        end

        // Enable drop while locked: immediate unlock, no pulses, freq_count held.
        enable = 0;
        step();
        chk("dis_lk", int'(locked), 0);
        chk("dis_ll", int'(lost_lock), 0);
        chk("dis_fc_hold", int'(freq_count), 1728);
        seen = 0;
        for (int i = 0; i < 70; i++) begin step(); seen += int'(count_valid); end
        chk("dis_cv_silent", seen, 0);

        // Gray counter wraps through 0 while locked.
        cnt = 16'hDD40;
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            wait_cv("wrap");
            chk("wrap_fc", int'(freq_count), 1728);
            chk("wrap_lk", int'(locked), i >= 3 ? 1 : 0);
        end

        // Retarget mid-window to divn=28.
        wait_cv("rt_sync");
        steps(20);
        divn = 28;
        rate = 28;
        step();
        chk("rt_lk", int'(locked), 0);
        chk("rt_ll", int'(lost_lock), 0);
        for (int i = 0; i < 4; i++) begin
            wait_cv("rt_relock");
            chk("rt_fc", int'(freq_count), 1792);
            chk("rt_lk4", int'(locked), i == 3 ? 1 : 0);
        end

        // Asynchronous reset mid-window, then restart from PRIME.
        steps(20);
        #3 reset = 1;
        #1;
        chk("ar_lk", int'(locked), 0);
        chk("ar_fc", int'(freq_count), 0);
        chk("ar_cv", int'(count_valid) + int'(lost_lock) + int'(freq_err), 0);
        steps(3);
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            wait_cv("ar_restart");
            chk("ar_restart_fc", int'(freq_count), 1792);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
